temporizador_vga: RTL and testbench
===================================

# temporizador_vga

Single-clock VGA timing sequencer for the 640x480@60 Hz display path. It produces a pixel-enable strobe from the system clock and runs horizontal and vertical segment state machines. It drives the sync, blank and pixel-coordinate outputs consumed by the text memory and output-control stages. It also schedules configuration updates from the chroma controller so they land only at the start of vertical blanking, which keeps colour changes tear-free.

## Interface
- CLK_DIV, 2: system-clock cycles per pixel (50 MHz -> 25 MHz); legal values ≥ 2.
- H_ACTIVE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal segment lengths in pixels.
- V_ACTIVE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical segment lengths in lines.
- Clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- PixelEn  out  1  one-Clock-wide strobe, once every CLK_DIV cycles.
- cuentaH  out  10  horizontal pixel count, 0..799.
- cuentaV  out  10  vertical line count, 0..524.
- Hsinc  out  1  horizontal sync, active low.
- Vsinc  out  1  vertical sync, active low.
- blank  out  1  high outside the 640x480 active area.
- FinLinea  out  1  high for one PixelEn cycle at cuentaH = 799.
- FinCuadro  out  1  high for one PixelEn cycle at cuentaH = 799, cuentaV = 524.
- cfg_req  in  1  level request from the chroma controller to apply new settings.
- cfg_ack  out  1  one-Clock pulse granting the update window.

## Operation
- Divider: counter 0..CLK_DIV-1. PixelEn = 1 in the cycle the counter equals CLK_DIV-1.
- All counters, FSMs and derived outputs advance only on cycles where PixelEn = 1. Outputs hold between strobes.
- H FSM states and exits:
  - H_ACT exits to H_FP after H_ACTIVE pixels.
  - H_FP exits to H_SYN after H_FRONT pixels.
  - H_SYN exits to H_BP after H_SYNC pixels.
  - H_BP exits to H_ACT after H_BACK pixels.
- cuentaH wraps 799 -> 0 on the H_BP -> H_ACT transition.
- V FSM has states V_ACT, V_FP, V_SYN and V_BP. It advances only when the line ends (FinLinea condition). cuentaV wraps 524 -> 0.
- Derived outputs:
  - Hsinc = 0 iff H state is H_SYN, i.e. cuentaH 656..751.
  - Vsinc = 0 iff V state is V_SYN, i.e. cuentaV 490..491.
  - blank = 1 iff H state ≠ H_ACT or V state ≠ V_ACT.
- All outputs are registered. Sync, blank and the Fin* flags describe the same pixel as the cuentaH/cuentaV values presented alongside them, with no skew.
- Update scheduler:
  - On the PixelEn cycle that moves V into V_FP (cuentaV becomes 480, cuentaH 0), cfg_ack pulses for exactly one Clock if cfg_req = 1 in that cycle.
  - A request raised after that point waits for the next frame's window.
  - The requester holds cfg_req until it sees cfg_ack, then deasserts it.
  - If cfg_req is still high at the next window, it is granted again.
- Segment lengths are summed at elaboration. The H and V totals must each be ≤ 1024; an elaboration error is raised otherwise.

## Timing
- Reset values:
  - Divider = 0, PixelEn = 0.
  - cuentaH = 0, cuentaV = 0; H state H_ACT, V state V_ACT.
  - Hsinc = 1, Vsinc = 1, blank = 0.
  - FinLinea = 0, FinCuadro = 0, cfg_ack = 0.
- First PixelEn occurs CLK_DIV cycles after reset deasserts. The first count change (cuentaH 0 -> 1) is registered on that edge.
- Reset asserted mid-frame forces all reset values on the next Clock edge, regardless of PixelEn or a pending cfg_req. There is no partial ack.
- Line period = 800 PixelEn = 1600 Clock. Frame period = 525 lines = 840 000 Clock.
- cfg_ack latency from window edge: 0 cycles (same edge as the cuentaV update).
- Simultaneous events:
  - End of line and end of frame are evaluated in the same cycle, so FinLinea and FinCuadro are both high.
  - If cfg_req rises in the exact window cycle, it is sampled and granted.

## Structure
- Package vga_pkg holds:
  - the default segment-length constants and the derived totals H_TOTAL and V_TOTAL;
  - the 2-bit segment-state typedef {ACT, FP, SYN, BP}, shared by the H and V FSMs.
- One sub-module, generador_pixel_en: the CLK_DIV divider producing PixelEn.
- The H/V FSMs, counters and scheduler stay in the top.

## Test plan
- Reset release, CLK_DIV = 2 -> PixelEn first high on Clock 2 and every 2nd cycle after; cuentaH reads 1 after the first strobe.
- Run one line -> Hsinc low exactly for cuentaH 656..751 (96 strobes); blank rises at cuentaH 640; FinLinea high only at 799; cuentaH wraps to 0 and cuentaV increments to 1.
- Run a full frame -> Vsinc low only for cuentaV 490..491; FinCuadro single-strobe at (799, 524); both counts return to (0, 0) at 840 000 Clocks.
- cfg_req raised at cuentaV = 100 -> cfg_ack one Clock wide at (0, 480); req dropped afterwards gives no further ack next frame.
- cfg_req raised at cuentaV = 481 and held -> no ack this frame; ack at (0, 480) of the next frame.
- reset pulsed at cuentaH = 700, cuentaV = 491 with Hsinc low and cfg_req high -> next edge shows counts 0, Hsinc = 1, Vsinc = 1, blank = 0, cfg_ack = 0.

Source files
------------

// File: rtl/temporizador_vga_pkg.sv
// Shared constants and segment-state type for the 640x480@60 Hz timing sequencer.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        SEG_ACT = 2'd0,
        SEG_FP  = 2'd1,
        SEG_SYN = 2'd2,
        SEG_BP  = 2'd3
    } seg_e;

endpackage

// File: rtl/generador_pixel_en.sv
// Clock divider producing a one-cycle pixel strobe every CLK_DIV system clocks.
module generador_pixel_en #(
    parameter int CLK_DIV = 2
) (
    input  logic Clock,
    input  logic reset,
    output logic PixelEn
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pe_q, pe_d;

    // Next divider value; strobe registered so it is high while the divider sits at its last value
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        pe_d = (div_d == DIV_LAST);
    end

    // Divider and strobe registers
    always_ff @(posedge Clock) begin
        if (reset) begin
            div_q <= '0;
            pe_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            pe_q  <= pe_d;
        end
    end

    assign PixelEn = pe_q;

endmodule

// File: rtl/temporizador_vga.sv
// VGA timing sequencer: H/V segment FSMs, pixel counters, registered sync/blank
// outputs and a configuration-update window aligned to the start of vertical blanking.
module temporizador_vga
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic       Clock,
    input  logic       reset,
    output logic       PixelEn,
    output logic [9:0] cuentaH,
    output logic [9:0] cuentaV,
    output logic       Hsinc,
    output logic       Vsinc,
    output logic       blank,
    output logic       FinLinea,
    output logic       FinCuadro,
    input  logic       cfg_req,
    output logic       cfg_ack
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOT > 1024) begin : g_h_total_err
        $error("temporizador_vga: horizontal total exceeds 1024");
    end
    if (V_TOT > 1024) begin : g_v_total_err
        $error("temporizador_vga: vertical total exceeds 1024");
    end

    logic       pixel_en_s;
    logic       line_end_s;
    seg_e       h_state_q, h_state_d, v_state_q, v_state_d;
    logic [9:0] cuentaH_q, cuentaH_d, cuentaV_q, cuentaV_d;
    logic       hsinc_q, hsinc_d, vsinc_q, vsinc_d, blank_q, blank_d;
    logic       fin_linea_q, fin_linea_d, fin_cuadro_q, fin_cuadro_d;
    logic       cfg_ack_q, cfg_ack_d;

    generador_pixel_en #(.CLK_DIV(CLK_DIV)) u_pixel_en (
        .Clock   (Clock),
        .reset   (reset),
        .PixelEn (pixel_en_s)
    );

    assign line_end_s = (cuentaH_q == 10'(H_TOT - 1));

    // Next-state logic: counters and FSMs move only on strobes, V only at line end
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        cuentaH_d = cuentaH_q;
        cuentaV_d = cuentaV_q;
        cfg_ack_d = 1'b0;
        if (pixel_en_s) begin
            cuentaH_d = line_end_s ? 10'd0 : cuentaH_q + 10'd1;
            case (h_state_q)
                SEG_ACT: if (cuentaH_q == 10'(H_ACTIVE - 1)) h_state_d = SEG_FP;
                SEG_FP:  if (cuentaH_q == 10'(H_ACTIVE + H_FRONT - 1)) h_state_d = SEG_SYN;
                SEG_SYN: if (cuentaH_q == 10'(H_ACTIVE + H_FRONT + H_SYNC - 1)) h_state_d = SEG_BP;
                SEG_BP:  if (line_end_s) h_state_d = SEG_ACT;
                default: h_state_d = SEG_ACT;
            endcase
            if (line_end_s) begin
                cuentaV_d = (cuentaV_q == 10'(V_TOT - 1)) ? 10'd0 : cuentaV_q + 10'd1;
                case (v_state_q)
                    SEG_ACT: if (cuentaV_q == 10'(V_ACTIVE - 1)) v_state_d = SEG_FP;
                    SEG_FP:  if (cuentaV_q == 10'(V_ACTIVE + V_FRONT - 1)) v_state_d = SEG_SYN;
                    SEG_SYN: if (cuentaV_q == 10'(V_ACTIVE + V_FRONT + V_SYNC - 1)) v_state_d = SEG_BP;
                    SEG_BP:  if (cuentaV_q == 10'(V_TOT - 1)) v_state_d = SEG_ACT;
                    default: v_state_d = SEG_ACT;
                endcase
            end else begin
                v_state_d = v_state_q;
            end
            // Grant window is the strobe entering vertical front porch
            cfg_ack_d = cfg_req && (v_state_q == SEG_ACT) && (v_state_d == SEG_FP);
        end else begin
            cfg_ack_d = 1'b0;
        end
        // Derived from next state so they register alongside the matching counts
        hsinc_d      = (h_state_d != SEG_SYN);
        vsinc_d      = (v_state_d != SEG_SYN);
        blank_d      = (h_state_d != SEG_ACT) || (v_state_d != SEG_ACT);
        fin_linea_d  = (cuentaH_d == 10'(H_TOT - 1));
        fin_cuadro_d = fin_linea_d && (cuentaV_d == 10'(V_TOT - 1));
    end

    // State, counter and output registers
    always_ff @(posedge Clock) begin
        if (reset) begin
            h_state_q    <= SEG_ACT;
            v_state_q    <= SEG_ACT;
            cuentaH_q    <= 10'd0;
            cuentaV_q    <= 10'd0;
            hsinc_q      <= 1'b1;
            vsinc_q      <= 1'b1;
            blank_q      <= 1'b0;
            fin_linea_q  <= 1'b0;
            fin_cuadro_q <= 1'b0;
            cfg_ack_q    <= 1'b0;
        end else begin
            h_state_q    <= h_state_d;
            v_state_q    <= v_state_d;
            cuentaH_q    <= cuentaH_d;
            cuentaV_q    <= cuentaV_d;
            hsinc_q      <= hsinc_d;
            vsinc_q      <= vsinc_d;
            blank_q      <= blank_d;
            fin_linea_q  <= fin_linea_d;
            fin_cuadro_q <= fin_cuadro_d;
            cfg_ack_q    <= cfg_ack_d;
        end
    end

    assign PixelEn   = pixel_en_s;
    assign cuentaH   = cuentaH_q;
    assign cuentaV   = cuentaV_q;
    assign Hsinc     = hsinc_q;
    assign Vsinc     = vsinc_q;
    assign blank     = blank_q;
    assign FinLinea  = fin_linea_q;
    assign FinCuadro = fin_cuadro_q;
    assign cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_temporizador_vga.sv
// Directed bench for temporizador_vga using scaled segment lengths (H 8/2/3/2, V 6/2/2/3).
module tb_temporizador_vga;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_req = 1'b0;
    logic       PixelEn, Hsinc, Vsinc, blank, FinLinea, FinCuadro, cfg_ack;
    logic [9:0] cuentaH, cuentaV;

    int n_checks = 0;
    int n_errors = 0;
    int m_div, m_h, m_v, n_ack;
    bit m_pe, m_ack, drop_on_ack;

    temporizador_vga #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clock(Clock), .reset(reset), .PixelEn(PixelEn), .cuentaH(cuentaH),
        .cuentaV(cuentaV), .Hsinc(Hsinc), .Vsinc(Vsinc), .blank(blank),
        .FinLinea(FinLinea), .FinCuadro(FinCuadro), .cfg_req(cfg_req), .cfg_ack(cfg_ack)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d (h=%0d v=%0d)", tag, obs, exp, m_h, m_v);
        end
    endtask

    // One clock: advance the reference model, then compare every output
    task automatic step();
        bit req_s, le;
        req_s = cfg_req;
        @(posedge Clock);
        if (reset) begin
            m_div = 0; m_pe = 0; m_h = 0; m_v = 0; m_ack = 0;
        end else begin
            m_ack = 0;
            if (m_pe) begin
                le = (m_h == HT - 1);
                m_ack = le && (m_v == VA - 1) && req_s;
                m_h = le ? 0 : m_h + 1;
                if (le) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
            m_div = (m_div + 1) % 2;
            m_pe = (m_div == 1);
        end
        #1;
        chk("pixel_en", int'(PixelEn), int'(m_pe));
        chk("cuentaH", int'(cuentaH), m_h);
        chk("cuentaV", int'(cuentaV), m_v);
        chk("hsinc", int'(Hsinc), (m_h >= HA + HF && m_h < HA + HF + HS) ? 0 : 1);
        chk("vsinc", int'(Vsinc), (m_v >= VA + VF && m_v < VA + VF + VS) ? 0 : 1);
        chk("blank", int'(blank), (m_h >= HA || m_v >= VA) ? 1 : 0);
        chk("fin_linea", int'(FinLinea), (m_h == HT - 1) ? 1 : 0);
        chk("fin_cuadro", int'(FinCuadro), (m_h == HT - 1 && m_v == VT - 1) ? 1 : 0);
        chk("cfg_ack", int'(cfg_ack), int'(m_ack));
        if (cfg_ack === 1'b1) begin
            n_ack++;
            if (drop_on_ack) cfg_req = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model reaches (h, v) just after a strobe edge, with a cycle budget
    task automatic run_to(input int h, input int v, input string tag);
        int k;
        k = 0;
        while (!(m_h == h && m_v == v && m_div == 0) && k < 4 * HT * VT) begin
            step();
            k++;
        end
        chk({tag, "_reached"}, (k < 4 * HT * VT) ? 1 : 0, 1);
    endtask

    initial begin
        drop_on_ack = 1'b1;
        n_ack = 0;
        // Reset state
        step();
        step();
        reset = 1'b0;
        // Release: strobe on the first edge, first count change on the second
        step();
        chk("first_strobe", int'(PixelEn), 1);
        chk("first_h_hold", int'(cuentaH), 0);
        step();
        chk("first_count", int'(cuentaH), 1);
        // One full frame plus a line with no request
        run(2 * HT * VT + 2 * HT);
        chk("no_req_acks", n_ack, 0);

        // Request raised early in the frame, dropped after the grant
        run_to(0, 1, "req_early");
        cfg_req = 1'b1;
        n_ack = 0;
        run(4 * HT * VT);
        chk("req_early_acks", n_ack, 1);
        chk("req_early_dropped", int'(cfg_req), 0);

        // Request raised after the window: granted only in the following frame
        run_to(0, VA + 1, "req_late");
        cfg_req = 1'b1;
        n_ack = 0;
        run_to(0, VA, "req_late_window");
        chk("req_late_acks", n_ack, 1);
        run(4 * HT * VT);
        chk("req_late_total", n_ack, 1);

        // Held request without drop: granted in each of two consecutive windows
        drop_on_ack = 1'b0;
        cfg_req = 1'b1;
        n_ack = 0;
        run(4 * HT * VT);
        chk("req_held_acks", n_ack, 2);
        cfg_req = 1'b0;
        drop_on_ack = 1'b1;

        // Mid-frame reset during both syncs with a request pending
        run_to(HA + HF + 1, VA + VF + 1, "mid_reset");
        chk("pre_reset_hsinc", int'(Hsinc), 0);
        chk("pre_reset_vsinc", int'(Vsinc), 0);
        cfg_req = 1'b1;
        reset = 1'b1;
        step();
        chk("rst_h", int'(cuentaH), 0);
        chk("rst_ack", int'(cfg_ack), 0);
        reset = 1'b0;
        cfg_req = 1'b0;
        run(3 * HT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
